// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared types and format constants for the pipelined FP multiplier
package fp_mul_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  typedef enum logic [1:0] {
    CL_NORM = 2'd0,
    CL_ZERO = 2'd1,
    CL_INF  = 2'd2,
    CL_NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] q;
    q = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    return q;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result stream interface of the FP multiplier
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rm, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, a, b, rm, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - stage-3 rounding, overflow/underflow handling and result packing
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    i_sign,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic [MAN_W-1:0]        i_frac,
  input  logic                    i_guard,
  input  logic                    i_round,
  input  logic                    i_sticky,
  input  rm_e                     i_rm,
  input  fp_class_e               i_cls,
  input  logic                    i_invalid,
  output logic [EXP_W+MAN_W:0]    o_y,
  output fp_flags_t               o_flags
);
  localparam logic signed [EXP_W+1:0] EXP_MAX_S = (EXP_W+2)'(fp_exp_max(EXP_W));
  localparam logic signed [EXP_W+1:0] ZERO_S    = '0;
  localparam logic [EXP_W+MAN_W:0]    QNAN      = (EXP_W+MAN_W+1)'(fp_qnan(EXP_W, MAN_W));

  logic                    w_lost;
  logic                    w_round_up;
  logic                    w_to_inf;
  logic [MAN_W:0]          w_inc;
  logic signed [EXP_W+1:0] w_exp_r;

  always_comb begin
    w_lost     = i_guard | i_round | i_sticky;
    w_round_up = 1'b0;
    case (i_rm)
      RM_RNE:  w_round_up = i_guard & (i_round | i_sticky | i_frac[0]);
      RM_RUP:  w_round_up = !i_sign & w_lost;
      RM_RDN:  w_round_up = i_sign & w_lost;
      default: w_round_up = 1'b0;
    endcase
    // Fraction overflow means 1.11..1 became 10.00..0: fraction is already zero, bump exponent.
    w_inc    = {1'b0, i_frac} + (MAN_W+1)'(w_round_up);
    w_exp_r  = i_exp + (EXP_W+2)'(w_inc[MAN_W]);
    w_to_inf = (i_rm == RM_RNE) || (i_rm == RM_RUP && !i_sign) || (i_rm == RM_RDN && i_sign);

    o_y     = '0;
    o_flags = '0;
    case (i_cls)
      CL_NAN: begin
        o_y             = QNAN;
        o_flags.invalid = i_invalid;
      end
      CL_INF:  o_y = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CL_ZERO: o_y = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (i_exp <= ZERO_S) begin
          o_y               = {i_sign, {(EXP_W+MAN_W){1'b0}}};
          o_flags.underflow = 1'b1;
          o_flags.inexact   = 1'b1;
        end else if (w_exp_r >= EXP_MAX_S) begin
          o_y              = w_to_inf ? {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                      : {i_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          o_flags.overflow = 1'b1;
          o_flags.inexact  = 1'b1;
        end else begin
          o_y             = {i_sign, w_exp_r[EXP_W-1:0], w_inc[MAN_W-1:0]};
          o_flags.inexact = w_lost;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-754 multiplier with valid/ready streaming and FTZ
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(fp_bias(EXP_W));

  logic                    w_en;
  logic                    w_sa, w_sb;
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_fa, w_fb;
  logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf;
  logic                    w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  fp_class_e               w_cls;
  logic                    w_invalid;
  logic signed [EXP_W+1:0] w_exp_sum;
  logic [PW-1:0]           w_prod;

  logic                    r1_valid, r1_sign, r1_invalid;
  logic signed [EXP_W+1:0] r1_exp;
  logic [PW-1:0]           r1_prod;
  rm_e                     r1_rm;
  fp_class_e               r1_cls;

  logic                    w_hi;
  logic signed [EXP_W+1:0] w_exp_n;
  logic [MAN_W-1:0]        w_frac_n;
  logic                    w_g, w_r, w_s;

  logic                    r2_valid, r2_sign, r2_invalid, r2_g, r2_r, r2_s;
  logic signed [EXP_W+1:0] r2_exp;
  logic [MAN_W-1:0]        r2_frac;
  rm_e                     r2_rm;
  fp_class_e               r2_cls;

  logic [W-1:0]            w_y;
  fp_flags_t               w_flags;
  logic                    r3_valid;
  logic [W-1:0]            r3_y;
  fp_flags_t               r3_flags;

  // Whole pipe advances together; a stalled output freezes every stage.
  assign w_en          = !r3_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r3_valid;
  assign bus.y         = r3_y;
  assign bus.flags     = r3_flags;

  assign {w_sa, w_ea, w_fa} = bus.a;
  assign {w_sb, w_eb, w_fb} = bus.b;

  // Zero exponent field covers subnormals too (flush-to-zero on input).
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];

  always_comb begin
    w_cls     = CL_NORM;
    w_invalid = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_cls     = CL_NAN;
      w_invalid = w_a_snan || w_b_snan;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_cls     = CL_NAN;
      w_invalid = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_cls = CL_INF;
    end else if (w_a_zero || w_b_zero) begin
      w_cls = CL_ZERO;
    end
  end

  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;
  assign w_prod    = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});

  // Product lies in [1,4): an MSB set means value >= 2, so drop one more bit and bump exp.
  assign w_hi     = r1_prod[PW-1];
  assign w_exp_n  = r1_exp + (EXP_W+2)'(w_hi);
  assign w_frac_n = w_hi ? r1_prod[2*MAN_W:MAN_W+1] : r1_prod[2*MAN_W-1:MAN_W];
  assign w_g      = w_hi ? r1_prod[MAN_W]   : r1_prod[MAN_W-1];
  assign w_r      = w_hi ? r1_prod[MAN_W-1] : r1_prod[MAN_W-2];
  assign w_s      = w_hi ? |r1_prod[MAN_W-2:0] : |r1_prod[MAN_W-3:0];

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .i_sign   (r2_sign),
    .i_exp    (r2_exp),
    .i_frac   (r2_frac),
    .i_guard  (r2_g),
    .i_round  (r2_r),
    .i_sticky (r2_s),
    .i_rm     (r2_rm),
    .i_cls    (r2_cls),
    .i_invalid(r2_invalid),
    .o_y      (w_y),
    .o_flags  (w_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_invalid <= 1'b0;
      r1_exp     <= '0;
      r1_prod    <= '0;
      r1_rm      <= RM_RNE;
      r1_cls     <= CL_ZERO;
      r2_valid   <= 1'b0;
      r2_sign    <= 1'b0;
      r2_invalid <= 1'b0;
      r2_g       <= 1'b0;
      r2_r       <= 1'b0;
      r2_s       <= 1'b0;
      r2_exp     <= '0;
      r2_frac    <= '0;
      r2_rm      <= RM_RNE;
      r2_cls     <= CL_ZERO;
      r3_valid   <= 1'b0;
      r3_y       <= '0;
      r3_flags   <= '0;
    end else if (w_en) begin
      r1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r1_sign    <= w_sa ^ w_sb;
        r1_invalid <= w_invalid;
        r1_exp     <= w_exp_sum;
        r1_prod    <= w_prod;
        r1_rm      <= rm_e'(bus.rm);
        r1_cls     <= w_cls;
      end
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign    <= r1_sign;
        r2_invalid <= r1_invalid;
        r2_g       <= w_g;
        r2_r       <= w_r;
        r2_s       <= w_s;
        r2_exp     <= w_exp_n;
        r2_frac    <= w_frac_n;
        r2_rm      <= r1_rm;
        r2_cls     <= r1_cls;
      end
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_y     <= w_y;
        r3_flags <= w_flags;
      end
    end
  end

endmodule
